// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one main-memory port between the icache and the dcache.
// Round-robin grant, held until the address (and write data) are handed off.
// Outstanding read owners are kept in an in-order FIFO so each memory
// response can be steered back to the cache that issued the read.
module mem_arbiter #(
    parameter int ADDR_W          = 28,
    parameter int DATA_W          = 128,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                ic_req_valid,
    output logic                ic_req_ready,
    input  logic [ADDR_W-1:0]   ic_req_addr,
    input  logic                ic_req_rw,
    input  logic                ic_req_data_valid,
    output logic                ic_req_data_ready,
    input  logic [DATA_W-1:0]   ic_req_data_bits,
    input  logic [DATA_W/8-1:0] ic_req_data_mask,
    output logic                ic_resp_valid,
    output logic [DATA_W-1:0]   ic_resp_data,

    input  logic                dc_req_valid,
    output logic                dc_req_ready,
    input  logic [ADDR_W-1:0]   dc_req_addr,
    input  logic                dc_req_rw,
    input  logic                dc_req_data_valid,
    output logic                dc_req_data_ready,
    input  logic [DATA_W-1:0]   dc_req_data_bits,
    input  logic [DATA_W/8-1:0] dc_req_data_mask,
    output logic                dc_resp_valid,
    output logic [DATA_W-1:0]   dc_resp_data,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic                mem_req_rw,
    output logic                mem_req_data_valid,
    input  logic                mem_req_data_ready,
    output logic [DATA_W-1:0]   mem_req_data_bits,
    output logic [DATA_W/8-1:0] mem_req_data_mask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_resp_data,

    output logic                err_orphan_resp
);
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam logic OWNER_IC = 1'b0;
    localparam logic OWNER_DC = 1'b1;

    typedef enum logic {IDLE, XFER} state_t;

    state_t           state_reg;
    logic             owner_reg;
    logic             rr_last_reg;
    logic             addr_done_reg;
    logic             data_done_reg;
    logic             err_orphan_reg;

    // Owner-id FIFO: tiny, so read asynchronously for zero-cycle steering.
    logic             fifo_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0] head_reg;
    logic [PTR_W-1:0] tail_reg;
    logic [PTR_W:0]   count_reg;

    logic               in_xfer;
    logic               own_valid;
    logic               own_rw;
    logic               own_dvalid;
    logic               fifo_full;
    logic               fifo_empty;
    logic               addr_hs;
    logic               data_hs;
    logic               push;
    logic               pop;
    logic               head_owner;
    logic               xfer_done;

    assign in_xfer    = (state_reg == XFER);
    assign own_valid  = owner_reg ? dc_req_valid      : ic_req_valid;
    assign own_rw     = owner_reg ? dc_req_rw         : ic_req_rw;
    assign own_dvalid = owner_reg ? dc_req_data_valid : ic_req_data_valid;

    assign fifo_full  = (count_reg == (PTR_W+1)'(MAX_OUTSTANDING));
    assign fifo_empty = (count_reg == '0);

    // Once a channel has handed off it is masked so memory never sees a repeat.
    assign mem_req_valid      = in_xfer & own_valid & ~addr_done_reg & ~(~own_rw & fifo_full);
    assign mem_req_data_valid = in_xfer & own_rw & own_dvalid & ~data_done_reg;
    assign mem_req_addr       = owner_reg ? dc_req_addr      : ic_req_addr;
    assign mem_req_rw         = own_rw;
    assign mem_req_data_bits  = owner_reg ? dc_req_data_bits : ic_req_data_bits;
    assign mem_req_data_mask  = owner_reg ? dc_req_data_mask : ic_req_data_mask;

    assign addr_hs = mem_req_valid & mem_req_ready;
    assign data_hs = mem_req_data_valid & mem_req_data_ready;

    assign ic_req_ready      = addr_hs & (owner_reg == OWNER_IC);
    assign dc_req_ready      = addr_hs & (owner_reg == OWNER_DC);
    assign ic_req_data_ready = data_hs & (owner_reg == OWNER_IC);
    assign dc_req_data_ready = data_hs & (owner_reg == OWNER_DC);

    assign push       = addr_hs & ~own_rw;
    assign pop        = mem_resp_valid & ~fifo_empty;
    assign head_owner = fifo_mem[head_reg];

    assign ic_resp_valid   = pop & (head_owner == OWNER_IC);
    assign dc_resp_valid   = pop & (head_owner == OWNER_DC);
    assign ic_resp_data    = mem_resp_data;
    assign dc_resp_data    = mem_resp_data;
    assign err_orphan_resp = err_orphan_reg;

    // A read is finished at its address handshake; a write needs both halves.
    assign xfer_done = in_xfer & (own_rw ? ((addr_done_reg | addr_hs) & (data_done_reg | data_hs))
                                         : addr_hs);

    // Arbitration FSM: grant in IDLE, hold the grant through the hand-off.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            owner_reg     <= OWNER_IC;
            rr_last_reg   <= OWNER_IC;
            addr_done_reg <= 1'b0;
            data_done_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (ic_req_valid && dc_req_valid) begin
                        owner_reg <= ~rr_last_reg;
                        state_reg <= XFER;
                    end else if (ic_req_valid) begin
                        owner_reg <= OWNER_IC;
                        state_reg <= XFER;
                    end else if (dc_req_valid) begin
                        owner_reg <= OWNER_DC;
                        state_reg <= XFER;
                    end
                end
                XFER: begin
                    if (xfer_done) begin
                        state_reg     <= IDLE;
                        addr_done_reg <= 1'b0;
                        data_done_reg <= 1'b0;
                        rr_last_reg   <= owner_reg;
                    end else begin
                        if (addr_hs) addr_done_reg <= 1'b1;
                        if (data_hs) data_done_reg <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Owner FIFO pointers and occupancy; push+pop together keeps the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push) tail_reg <= tail_reg + 1'b1;
            if (pop)  head_reg <= head_reg + 1'b1;
            if (push && !pop)      count_reg <= count_reg + 1'b1;
            else if (!push && pop) count_reg <= count_reg - 1'b1;
        end
    end

    // Owner FIFO storage, one write-enabled entry per slot.
    generate
        for (genvar gi = 0; gi < MAX_OUTSTANDING; gi++) begin : g_fifo_entry
            // Capture the reading owner when the tail points at this slot.
            always_ff @(posedge clk) begin
                if (push && (tail_reg == PTR_W'(gi))) fifo_mem[gi] <= owner_reg;
            end
        end
    endgenerate

    // Sticky flag for a response that has no read waiting for it.
    always_ff @(posedge clk) begin
        if (reset)                              err_orphan_reg <= 1'b0;
        else if (mem_resp_valid && fifo_empty)  err_orphan_reg <= 1'b1;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios with literal checks, plus a
// transaction-level model (grant holder + queue of read owners) compared
// against the DUT on every falling edge.
module tb_mem_arbiter;
    localparam int ADDR_W = 28;
    localparam int DATA_W = 128;
    localparam int MASK_W = DATA_W/8;
    localparam int MAX_OUTSTANDING = 4;
    localparam int IC = 0;
    localparam int DC = 1;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic ic_req_valid = 0, ic_req_ready, ic_req_rw = 0, ic_req_data_valid = 0, ic_req_data_ready;
    logic [ADDR_W-1:0] ic_req_addr = '0;
    logic [DATA_W-1:0] ic_req_data_bits = '0, ic_resp_data;
    logic [MASK_W-1:0] ic_req_data_mask = '0;
    logic ic_resp_valid;

    logic dc_req_valid = 0, dc_req_ready, dc_req_rw = 0, dc_req_data_valid = 0, dc_req_data_ready;
    logic [ADDR_W-1:0] dc_req_addr = '0;
    logic [DATA_W-1:0] dc_req_data_bits = '0, dc_resp_data;
    logic [MASK_W-1:0] dc_req_data_mask = '0;
    logic dc_resp_valid;

    logic mem_req_valid, mem_req_rw, mem_req_data_valid;
    logic mem_req_ready = 1, mem_req_data_ready = 1, mem_resp_valid = 0;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_data_bits, mem_resp_data = '0;
    logic [MASK_W-1:0] mem_req_data_mask;
    logic err_orphan_resp;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTSTANDING(MAX_OUTSTANDING)) dut (
        .clk(clk), .reset(reset),
        .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr),
        .ic_req_rw(ic_req_rw), .ic_req_data_valid(ic_req_data_valid),
        .ic_req_data_ready(ic_req_data_ready), .ic_req_data_bits(ic_req_data_bits),
        .ic_req_data_mask(ic_req_data_mask), .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
        .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_addr(dc_req_addr),
        .dc_req_rw(dc_req_rw), .dc_req_data_valid(dc_req_data_valid),
        .dc_req_data_ready(dc_req_data_ready), .dc_req_data_bits(dc_req_data_bits),
        .dc_req_data_mask(dc_req_data_mask), .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_rw(mem_req_rw), .mem_req_data_valid(mem_req_data_valid),
        .mem_req_data_ready(mem_req_data_ready), .mem_req_data_bits(mem_req_data_bits),
        .mem_req_data_mask(mem_req_data_mask), .mem_resp_valid(mem_resp_valid),
        .mem_resp_data(mem_resp_data), .err_orphan_resp(err_orphan_resp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    int   m_grant   = -1;     // client holding the port, -1 when none
    int   m_rr_last = IC;
    bit   m_addr_got = 0, m_data_got = 0, m_err = 0;
    int   m_owners[$];        // reads awaiting a response, oldest first

    task automatic model_cycle();
        logic g_valid, g_rw, g_dvalid, e_mv, e_dv, ahs, dhs, e_icrv, e_dcrv;
        logic [ADDR_W-1:0] g_addr;
        logic [DATA_W-1:0] g_bits;
        logic [MASK_W-1:0] g_mask;
        g_valid = 0; g_rw = 0; g_dvalid = 0; g_addr = '0; g_bits = '0; g_mask = '0;
        if (m_grant == IC) begin
            g_valid = ic_req_valid; g_rw = ic_req_rw; g_dvalid = ic_req_data_valid;
            g_addr = ic_req_addr; g_bits = ic_req_data_bits; g_mask = ic_req_data_mask;
        end else if (m_grant == DC) begin
            g_valid = dc_req_valid; g_rw = dc_req_rw; g_dvalid = dc_req_data_valid;
            g_addr = dc_req_addr; g_bits = dc_req_data_bits; g_mask = dc_req_data_mask;
        end
        e_mv = (m_grant >= 0) && g_valid && !m_addr_got
               && !(!g_rw && m_owners.size() == MAX_OUTSTANDING);
        e_dv = (m_grant >= 0) && g_rw && g_dvalid && !m_data_got;
        ahs  = e_mv && mem_req_ready;
        dhs  = e_dv && mem_req_data_ready;
        e_icrv = mem_resp_valid && m_owners.size() > 0 && m_owners[0] == IC;
        e_dcrv = mem_resp_valid && m_owners.size() > 0 && m_owners[0] == DC;

        chk("m.mem_req_valid", mem_req_valid, e_mv);
        chk("m.mem_req_data_valid", mem_req_data_valid, e_dv);
        chk("m.ic_req_ready", ic_req_ready, ahs && m_grant == IC);
        chk("m.dc_req_ready", dc_req_ready, ahs && m_grant == DC);
        chk("m.ic_req_data_ready", ic_req_data_ready, dhs && m_grant == IC);
        chk("m.dc_req_data_ready", dc_req_data_ready, dhs && m_grant == DC);
        chk("m.ic_resp_valid", ic_resp_valid, e_icrv);
        chk("m.dc_resp_valid", dc_resp_valid, e_dcrv);
        chk("m.err_orphan_resp", err_orphan_resp, m_err);
        if (e_mv) begin
            chk("m.mem_req_addr", mem_req_addr, g_addr);
            chk("m.mem_req_rw", mem_req_rw, g_rw);
        end
        if (e_dv) begin
            chk("m.mem_req_data_bits", mem_req_data_bits, g_bits);
            chk("m.mem_req_data_mask", mem_req_data_mask, g_mask);
        end

        if (reset) begin
            m_grant = -1; m_rr_last = IC; m_addr_got = 0; m_data_got = 0; m_err = 0;
            m_owners.delete();
        end else begin
            if (mem_resp_valid) begin
                if (m_owners.size() == 0) m_err = 1;
                else void'(m_owners.pop_front());
            end
            if (m_grant < 0) begin
                if (ic_req_valid && dc_req_valid) m_grant = 1 - m_rr_last;
                else if (ic_req_valid)           m_grant = IC;
                else if (dc_req_valid)           m_grant = DC;
            end else begin
                if (ahs && !g_rw) m_owners.push_back(m_grant);
                m_addr_got = m_addr_got || ahs;
                m_data_got = m_data_got || dhs;
                if (g_rw ? (m_addr_got && m_data_got) : ahs) begin
                    m_rr_last = m_grant; m_grant = -1; m_addr_got = 0; m_data_got = 0;
                end
            end
        end
    endtask

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            model_cycle();
        end
    end

    // One clock; clients drop valid after their handshake, as a cache would.
    task automatic tick();
        logic ic_hs, dc_hs, ic_dhs, dc_dhs;
        @(negedge clk);
        ic_hs  = ic_req_valid & ic_req_ready;
        dc_hs  = dc_req_valid & dc_req_ready;
        ic_dhs = ic_req_data_valid & ic_req_data_ready;
        dc_dhs = dc_req_data_valid & dc_req_data_ready;
        @(posedge clk);
        #1;
        if (ic_hs)  ic_req_valid = 0;
        if (dc_hs)  dc_req_valid = 0;
        if (ic_dhs) ic_req_data_valid = 0;
        if (dc_dhs) dc_req_data_valid = 0;
    endtask

    task automatic do_reset();
        reset = 1; tick(); tick(); reset = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] pat_a5;
        pat_a5 = {16{8'hA5}};
        do_reset();
        #1;
        $display("txn: reset state");
        chk("rst.mem_req_valid", mem_req_valid, 0);
        chk("rst.ic_req_ready", ic_req_ready, 0);
        chk("rst.dc_req_ready", dc_req_ready, 0);
        chk("rst.err", err_orphan_resp, 0);

        // ic read alone
        $display("txn: ic read 0x0000010");
        ic_req_valid = 1; ic_req_rw = 0; ic_req_addr = 28'h0000010;
        #1 chk("t1.idle_no_valid", mem_req_valid, 0);
        tick();
        chk("t1.mem_req_valid", mem_req_valid, 1);
        chk("t1.addr", mem_req_addr, 28'h0000010);
        chk("t1.rw", mem_req_rw, 0);
        tick(); tick(); tick();
        mem_resp_valid = 1; mem_resp_data = pat_a5;
        #1 chk("t1.ic_resp_valid", ic_resp_valid, 1);
        chk("t1.dc_resp_valid", dc_resp_valid, 0);
        chk("t1.ic_resp_data", ic_resp_data, pat_a5);
        tick(); mem_resp_valid = 0;
        #1 chk("t1.ic_resp_one_cycle", ic_resp_valid, 0);

        // simultaneous reads after reset: dc first
        do_reset();
        $display("txn: ic read 0x100 and dc read 0x200 together");
        ic_req_valid = 1; ic_req_rw = 0; ic_req_addr = 28'h100;
        dc_req_valid = 1; dc_req_rw = 0; dc_req_addr = 28'h200;
        tick();
        chk("t2.dc_first", dc_req_ready, 1);
        chk("t2.ic_waits", ic_req_ready, 0);
        chk("t2.addr_dc", mem_req_addr, 28'h200);
        tick();
        chk("t2.bubble", mem_req_valid, 0);
        tick();
        chk("t2.ic_second", ic_req_ready, 1);
        chk("t2.addr_ic", mem_req_addr, 28'h100);
        tick();
        mem_resp_valid = 1; mem_resp_data = 128'h1;
        #1 chk("t2.r1_to_dc", dc_resp_valid, 1);
        tick(); mem_resp_data = 128'h2;
        #1 chk("t2.r2_to_ic", ic_resp_valid, 1);
        tick(); mem_resp_valid = 0;

        // dc write with late data, ic read waiting
        $display("txn: dc write 0x20 mask ffff, ic read 0x30 waiting");
        mem_req_data_ready = 0;
        dc_req_valid = 1; dc_req_rw = 1; dc_req_addr = 28'h20; dc_req_data_valid = 1;
        dc_req_data_bits = 128'hDEADBEEF_00000000_CAFEF00D_12345678; dc_req_data_mask = 16'hFFFF;
        ic_req_valid = 1; ic_req_rw = 0; ic_req_addr = 28'h30;
        tick();
        chk("t3.dc_ready", dc_req_ready, 1);
        chk("t3.dc_data_not_ready", dc_req_data_ready, 0);
        chk("t3.mask", mem_req_data_mask, 16'hFFFF);
        tick();
        chk("t3.ic_held_1", ic_req_ready, 0);
        chk("t3.no_readdr", mem_req_valid, 0);
        tick();
        chk("t3.ic_held_2", ic_req_ready, 0);
        tick();
        mem_req_data_ready = 1;
        #1 chk("t3.data_hs", dc_req_data_ready, 1);
        chk("t3.ic_held_3", ic_req_ready, 0);
        tick();
        chk("t3.bubble", ic_req_ready, 0);
        tick();
        chk("t3.ic_granted", ic_req_ready, 1);
        tick();
        mem_resp_valid = 1;
        #1 chk("t3.ic_resp", ic_resp_valid, 1);
        tick(); mem_resp_valid = 0;

        // fill the owner FIFO with dc reads
        for (int i = 0; i < 4; i++) begin
            $display("txn: dc read 0x%0h", 28'h40 + i);
            dc_req_valid = 1; dc_req_rw = 0; dc_req_addr = 28'h40 + 28'(i);
            tick();
            chk("t4.dc_fill", dc_req_ready, 1);
            tick();
        end
        $display("txn: ic read 0x50 with FIFO full");
        ic_req_valid = 1; ic_req_rw = 0; ic_req_addr = 28'h50;
        tick();
        chk("t4.full_blocks", mem_req_valid, 0);
        tick();
        chk("t4.full_holds", ic_req_ready, 0);
        mem_resp_valid = 1; mem_resp_data = 128'h11;
        #1 chk("t4.resp1_dc", dc_resp_valid, 1);
        chk("t4.still_full", mem_req_valid, 0);
        tick(); mem_resp_data = 128'h12;
        #1 chk("t4.freed", ic_req_ready, 1);
        chk("t4.pushpop_resp_dc", dc_resp_valid, 1);
        tick(); mem_resp_valid = 0;
        $display("txn: dc read 0x60 fills to 4");
        dc_req_valid = 1; dc_req_rw = 0; dc_req_addr = 28'h60;
        tick();
        chk("t4.count_was_3", dc_req_ready, 1);
        tick();
        $display("txn: ic read 0x70 with FIFO full");
        ic_req_valid = 1; ic_req_rw = 0; ic_req_addr = 28'h70;
        tick();
        chk("t4.full_again", mem_req_valid, 0);
        mem_resp_valid = 1;
        #1 chk("t4.drain_dc1", dc_resp_valid, 1);
        tick();
        chk("t4.drain_dc2", dc_resp_valid, 1);
        chk("t4.ic70_ok", ic_req_ready, 1);
        tick();
        chk("t4.drain_ic50", ic_resp_valid, 1);
        tick();
        chk("t4.drain_dc60", dc_resp_valid, 1);
        tick();
        chk("t4.drain_ic70", ic_resp_valid, 1);
        tick(); mem_resp_valid = 0;

        // orphan response
        $display("txn: orphan response");
        mem_resp_valid = 1;
        #1 chk("t5.no_ic", ic_resp_valid, 0);
        chk("t5.no_dc", dc_resp_valid, 0);
        tick(); mem_resp_valid = 0;
        #1 chk("t5.err_set", err_orphan_resp, 1);
        tick(); tick();
        chk("t5.err_sticky", err_orphan_resp, 1);

        // reset during a half-finished write
        $display("txn: ic write 0x80 interrupted by reset");
        mem_req_data_ready = 0;
        ic_req_valid = 1; ic_req_rw = 1; ic_req_addr = 28'h80; ic_req_data_valid = 1;
        ic_req_data_bits = 128'h55; ic_req_data_mask = 16'h000F;
        tick();
        chk("t6.addr_hs", ic_req_ready, 1);
        tick();
        chk("t6.data_pending", mem_req_data_valid, 1);
        reset = 1; ic_req_data_valid = 0;
        tick();
        chk("t6.ic_ready0", ic_req_ready, 0);
        chk("t6.ic_data_ready0", ic_req_data_ready, 0);
        chk("t6.mem_valid0", mem_req_valid, 0);
        chk("t6.err_cleared", err_orphan_resp, 0);
        reset = 0; mem_req_data_ready = 1;
        $display("txn: ic read 0x90 after reset");
        ic_req_valid = 1; ic_req_rw = 0; ic_req_addr = 28'h90;
        tick();
        chk("t6.new_read", ic_req_ready, 1);
        chk("t6.new_addr", mem_req_addr, 28'h90);
        tick();
        mem_resp_valid = 1;
        #1 chk("t6.resp", ic_resp_valid, 1);
        tick(); mem_resp_valid = 0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
